detect_event_logger: RTL and testbench
======================================

Name: detect_event_logger

Overview:
- Downstream consumer of the 1001 sequence-detector `detect` output.
- Timestamps each detect pulse against a free-running cycle counter and tags it with a sequence number.
- Buffers events in a small FIFO and presents them on a valid/ready stream to the host/readout logic.
- Tracks overflow: sticky flag plus saturating drop counter.

Parameters:
TS_W, 16, width of free-running timestamp counter and event timestamp
SEQ_W, 8, width of event sequence number (wraps)
DEPTH, 4, FIFO entries; power of two, >= 2
DROP_W, 8, width of saturating dropped-event counter

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
detect  input  1  detection pulse from sequence detector; sampled each posedge
ev_ready  input  1  downstream ready
ev_valid  output  1  FIFO head holds an event
ev_timestamp  output  TS_W  timestamp of head event
ev_seq  output  SEQ_W  sequence number of head event
level  output  clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one event dropped since reset
drop_count  output  DROP_W  dropped events, saturating at all-ones

Behaviour:
- Reset (reset==0 at posedge):
  - ts=0, seq=0, FIFO emptied (pointers 0, level=0), ev_valid=0, overflow=0, drop_count=0.
  - ev_timestamp/ev_seq read as 0 while empty after reset.
  - Reset takes priority over every other event, including mid-stream with FIFO partially full; all pending events are discarded.
- Timestamp:
  - ts increments by 1 each non-reset posedge and wraps modulo 2^TS_W.
  - ts reads 0 in the first cycle after reset is released.
- Capture:
  - If detect==1 at a posedge, the event gets {timestamp = ts value before that edge's increment, seq = current seq}.
  - seq increments on every detect, whether the event is stored or dropped, so gaps in ev_seq expose drops.
- Push:
  - Accepted if FIFO not full, or if full and a pop occurs on the same edge (simultaneous pop frees the slot).
  - Otherwise the event is dropped: overflow<=1, drop_count<=drop_count+1, saturating at 2^DROP_W-1.
- Pop: occurs when ev_valid && ev_ready at posedge; the head advances.
- Outputs:
  - ev_valid = (level != 0), driven from registered state.
  - ev_timestamp/ev_seq are the head entry and stay stable while ev_valid && !ev_ready.
- Latency: detect at edge k into an empty FIFO gives ev_valid=1 in the cycle after edge k. There is no combinational bypass.
- Simultaneous push and pop: level unchanged. Empty + push + (ev_ready==1) yields no pop, since ev_valid was 0.
- level:
  - +1 on push only, -1 on pop only, unchanged otherwise.
  - Never exceeds DEPTH, never underflows.
  - ev_ready while empty has no effect.
- Pointers wrap modulo DEPTH. Full/empty are distinguished via level (or an extra pointer bit).
- overflow and drop_count clear only on reset.

Test Plan:
1. Reset sampled low for 2 edges, then high; no detect -> all outputs 0; after 5 edges internal ts=5, ev_valid=0, level=0.
2. ev_ready=1; single detect pulse in cycle where ts=7 -> next cycle ev_valid=1, ev_timestamp=7, ev_seq=0; popped on following edge; level returns to 0.
3. ev_ready=0; 5 detects in consecutive cycles at ts=10..14 -> FIFO holds ts 10,11,12,13 with seq 0..3, level=4; 5th dropped: overflow=1, drop_count=1. Raise ev_ready, drain -> seq 0,1,2,3. Next detect gets seq=5 (gap shows drop).
4. FIFO full (level=4), ev_ready=1, detect=1 same edge -> head popped and new event stored; level stays 4; overflow unchanged; new event emerges last with correct ts/seq.
5. Hold ev_ready=0, FIFO full, 300 further detects -> drop_count saturates at 255, overflow=1, stored entries unchanged and ev_timestamp stable throughout.
6. level=3 mid-stream; assert reset low one edge with detect=1 -> level=0, ev_valid=0, seq=0, ts=0, overflow=0, drop_count=0. Also run ts across 65535->0 wrap with a detect at ts=65535 and at ts=0, capturing 65535 then 0.

Source files
------------

// File: rtl/detect_event_logger_if.sv
// Valid/ready event stream carrying a timestamped, sequence-tagged detection.
// The logger drives through master; the host/readout side uses slave.
interface detect_event_logger_if #(
  parameter int TS_W  = 16,
  parameter int SEQ_W = 8
);

  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W-1:0]  ev_timestamp;
  logic [SEQ_W-1:0] ev_seq;

  modport master (
    output ev_valid,
    output ev_timestamp,
    output ev_seq,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_timestamp,
    input  ev_seq,
    output ev_ready
  );

endinterface

// File: rtl/detect_event_logger.sv
// Timestamps sequence-detector pulses, queues them in a small FIFO and streams
// them out on valid/ready, counting events lost to a full queue.
module detect_event_logger #(
  parameter int TS_W   = 16,
  parameter int SEQ_W  = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     detect,
  detect_event_logger_if.master    ev,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]  ts;
  logic [SEQ_W-1:0] seq;

  logic [TS_W-1:0]  ts_mem  [DEPTH];
  logic [SEQ_W-1:0] seq_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;

  logic             not_empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    not_empty = (count != '0);
    full      = (count == LW'(DEPTH));
    pop       = not_empty && ev.ev_ready;
    push      = detect && (!full || pop);
    drop      = detect && !push;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts  <= '0;
      seq <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (detect) begin
        seq <= seq + SEQ_W'(1);
      end
    end
  end

  // Storage is never cleared; stale slots are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ts_mem[wr_ptr]  <= ts;
      seq_mem[wr_ptr] <= seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  // Head fields are masked while empty so a reset never exposes stale entries.
  always_comb begin
    ev.ev_valid     = not_empty;
    ev.ev_timestamp = not_empty ? ts_mem[rd_ptr]  : '0;
    ev.ev_seq       = not_empty ? seq_mem[rd_ptr] : '0;
    level           = count;
  end

endmodule

// File: tb/tb_detect_event_logger.sv
// Directed bench for detect_event_logger: reset, single event, overflow,
// full-with-pop, drop-counter saturation, mid-stream reset and timestamp wrap.
module tb_detect_event_logger;

  logic        clk;
  logic        reset;
  logic        detect;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [15:0] ts_model;
  logic [15:0] exp_ts;
  int          checks;
  int          errors;

  detect_event_logger_if #(.TS_W(16), .SEQ_W(8)) ev();

  detect_event_logger #(
    .TS_W(16), .SEQ_W(8), .DEPTH(4), .DROP_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .detect     (detect),
    .ev         (ev),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running counter: the value the logger should stamp.
  always @(posedge clk) begin
    if (!reset) ts_model <= '0;
    else        ts_model <= ts_model + 16'd1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic r);
    detect      = d;
    ev.ev_ready = r;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", 32'(ev.ev_valid), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_drop", 32'(drop_count), 0);
    checkOutput("rst_ts", 32'(ev.ev_timestamp), 0);
    checkOutput("rst_seq", 32'(ev.ev_seq), 0);
    reset = 1'b1;

    repeat (5) tick();
    checkOutput("idle_valid", 32'(ev.ev_valid), 0);
    checkOutput("idle_level", 32'(level), 0);

    // Single event at ts=7 with ready high: visible one cycle, then popped.
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("single_valid", 32'(ev.ev_valid), 1);
    checkOutput("single_ts", 32'(ev.ev_timestamp), 7);
    checkOutput("single_seq", 32'(ev.ev_seq), 0);
    checkOutput("single_level", 32'(level), 1);
    tick();
    checkOutput("single_popped_valid", 32'(ev.ev_valid), 0);
    checkOutput("single_popped_level", 32'(level), 0);

    // Five back-to-back detects at ts 10..14 with ready low: fifth one drops.
    doReset();
    applyStimulus(1'b0, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b1, 1'b0);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("ovf_level", 32'(level), 4);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("ovf_drop", 32'(drop_count), 1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_drain_ts", 32'(ev.ev_timestamp), 32'(10 + i));
      checkOutput("ovf_drain_seq", 32'(ev.ev_seq), 32'(i));
      tick();
    end
    checkOutput("ovf_drained_level", 32'(level), 0);
    checkOutput("ovf_drained_valid", 32'(ev.ev_valid), 0);
    applyStimulus(1'b1, 1'b0);
    exp_ts = ts_model;
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_seq", 32'(ev.ev_seq), 5);
    checkOutput("gap_ts", 32'(ev.ev_timestamp), 32'(exp_ts));

    // Full FIFO with pop and push on the same edge keeps level at 4.
    doReset();
    applyStimulus(1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("full_level", 32'(level), 4);
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("pushpop_level", 32'(level), 4);
    checkOutput("pushpop_overflow", 32'(overflow), 0);
    checkOutput("pushpop_drop", 32'(drop_count), 0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("pushpop_drain_seq", 32'(ev.ev_seq), 32'(i));
      checkOutput("pushpop_drain_ts", 32'(ev.ev_timestamp), 32'(i));
      tick();
    end
    checkOutput("pushpop_empty", 32'(level), 0);

    // 300 detects into a full FIFO: counter saturates, head never moves.
    applyStimulus(1'b1, 1'b0);
    exp_ts = ts_model;
    repeat (4) tick();
    for (int i = 0; i < 300; i++) begin
      tick();
      checkOutput("sat_head_ts", 32'(ev.ev_timestamp), 32'(exp_ts));
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("sat_drop", 32'(drop_count), 255);
    checkOutput("sat_overflow", 32'(overflow), 1);
    checkOutput("sat_level", 32'(level), 4);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sat_drain_seq", 32'(ev.ev_seq), 32'(5 + i));
      checkOutput("sat_drain_ts", 32'(ev.ev_timestamp), 32'(exp_ts + 16'(i)));
      tick();
    end
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("sat_next_seq", 32'(ev.ev_seq), 53);

    // Reset with three events pending and detect high discards everything.
    repeat (2) tick();
    checkOutput("midrst_pre_level", 32'(level), 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("midrst_level", 32'(level), 0);
    checkOutput("midrst_valid", 32'(ev.ev_valid), 0);
    checkOutput("midrst_overflow", 32'(overflow), 0);
    checkOutput("midrst_drop", 32'(drop_count), 0);
    checkOutput("midrst_ts", 32'(ev.ev_timestamp), 0);
    checkOutput("midrst_seq", 32'(ev.ev_seq), 0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst_cap_level", 32'(level), 2);
    checkOutput("midrst_cap_seq", 32'(ev.ev_seq), 0);
    checkOutput("midrst_cap_ts", 32'(ev.ev_timestamp), 0);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("midrst_second_seq", 32'(ev.ev_seq), 1);
    checkOutput("midrst_second_ts", 32'(ev.ev_timestamp), 1);

    // Timestamp wrap: events at ts=65535 and ts=0.
    doReset();
    applyStimulus(1'b0, 1'b1);
    repeat (65535) tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("wrap_hi_ts", 32'(ev.ev_timestamp), 65535);
    checkOutput("wrap_hi_seq", 32'(ev.ev_seq), 0);
    checkOutput("wrap_hi_level", 32'(level), 1);
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_lo_ts", 32'(ev.ev_timestamp), 0);
    checkOutput("wrap_lo_seq", 32'(ev.ev_seq), 1);
    checkOutput("wrap_lo_level", 32'(level), 1);
    tick();
    checkOutput("wrap_empty", 32'(level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
